// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-side pipeline controller (RAW stall, branch flush,
// HALT drain, stall/flush counters). Optional macro: PIPE_HAZARD_FWD_EN.
// Ports: clk, reset (sync, active-high); inst_f_if = instruction in ID;
//   rd_f_*/wr_f_* = dest reg and write flag of EX/MEM/WB; mem_read_f_ex =
//   EX is a load; branch_taken_f_ex = taken-branch pulse from EX.
//   pc_en, if_id_en, if_id_flush, id_ex_bubble = pipeline register control;
//   halted = core stopped; fwd_a_sel/fwd_b_sel = operand bypass select;
//   stall_cnt/flush_cnt = saturating performance counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst_f_if,
   input  logic [4:0]       rd_f_ex,
   input  logic             wr_f_ex,
   input  logic             mem_read_f_ex,
   input  logic [4:0]       rd_f_mem,
   input  logic             wr_f_mem,
   input  logic [4:0]       rd_f_wb,
   input  logic             wr_f_wb,
   input  logic             branch_taken_f_ex,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             halted,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [5:0] OP_HALT = 6'h11;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [DW-1:0]  drain, drain_n;
   logic [5:0]     op;
   logic [4:0]     rs, rt;
   logic           use_rs, use_rt;
   logic           ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
   logic           hazard;
   logic [1:0]     fa, fb;
   logic           stall_inc, flush_inc;
   logic           unused_bits;

   assign op = inst_f_if[31:26];
   assign rs = inst_f_if[25:21];
   assign rt = inst_f_if[20:16];

   always_comb begin
      use_rs = 1'b0;
      use_rt = 1'b0;
      case (op)
         6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A,
         6'h0D, 6'h0F: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B,
         6'h0C, 6'h0E, 6'h10:
            use_rs = 1'b1;
         default: ;
      endcase
   end

   function automatic logic hit(input logic       used,
                                input logic [4:0] src,
                                input logic [4:0] rd,
                                input logic       wr);
      return used && wr && (rd != 5'd0) && (src == rd);
   endfunction

   assign ex_a  = hit(use_rs, rs, rd_f_ex, wr_f_ex);
   assign ex_b  = hit(use_rt, rt, rd_f_ex, wr_f_ex);
   assign mem_a = hit(use_rs, rs, rd_f_mem, wr_f_mem);
   assign mem_b = hit(use_rt, rt, rd_f_mem, wr_f_mem);
   assign wb_a  = hit(use_rs, rs, rd_f_wb, wr_f_wb);
   assign wb_b  = hit(use_rt, rt, rd_f_wb, wr_f_wb);

`ifdef PIPE_HAZARD_FWD_EN
   // Only a load in EX cannot be bypassed; MEM beats WB (younger value).
   assign hazard = mem_read_f_ex && (ex_a || ex_b);
   assign fa = mem_a ? 2'd1 : (wb_a ? 2'd2 : 2'd0);
   assign fb = mem_b ? 2'd1 : (wb_b ? 2'd2 : 2'd0);
   assign unused_bits = ^inst_f_if[15:0];
`else
   // WB counts: the register file is written only at the clock edge.
   assign hazard = ex_a || ex_b || mem_a || mem_b || wb_a || wb_b;
   assign fa = 2'd0;
   assign fb = 2'd0;
   assign unused_bits = ^{inst_f_if[15:0], mem_read_f_ex};
`endif

   assign fwd_a_sel = reset ? 2'd0 : fa;
   assign fwd_b_sel = reset ? 2'd0 : fb;

   always_comb begin
      state_n      = state;
      drain_n      = drain;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (reset) begin
         if_id_flush = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               // Taken branch outranks anything in ID: it is wrong-path.
               if (branch_taken_f_ex) begin
                  pc_en       = 1'b1;
                  if_id_en    = 1'b1;
                  if_id_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else if (hazard) begin
                  stall_inc = 1'b1;
               end else if (op == OP_HALT) begin
                  drain_n = DW'(DRAIN_CYC - 1);
                  state_n = DRAIN;
               end else begin
                  pc_en        = 1'b1;
                  if_id_en     = 1'b1;
                  id_ex_bubble = 1'b0;
               end
            end
            DRAIN: begin
               if (drain == '0) state_n = HALTED;
               else             drain_n = drain - 1'b1;
            end
            HALTED: ;
            default: state_n = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         drain     <= '0;
         halted    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state  <= state_n;
         drain  <= drain_n;
         halted <= (state_n == HALTED);
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle sequences
// for pipe_hazard_ctrl (CNT_W=4, DRAIN_CYC=3).
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;
`ifdef PIPE_HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      inst;
   logic [4:0]       rex, rmem, rwb;
   logic             wex, mrex, wmem, wwb, br;
   logic             pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_st, exp_fl;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(3)) dut (
      .clk(clk), .reset(reset), .inst_f_if(inst),
      .rd_f_ex(rex), .wr_f_ex(wex), .mem_read_f_ex(mrex),
      .rd_f_mem(rmem), .wr_f_mem(wmem),
      .rd_f_wb(rwb), .wr_f_wb(wwb),
      .branch_taken_f_ex(br),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .halted(halted),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  rex;
      logic        wex, mrex;
      logic [4:0]  rmem;
      logic        wmem;
      logic [4:0]  rwb;
      logic        wwb, br, st_nf, st_fw;
      logic [1:0]  fa, fb;
   } vec_t;

   vec_t v[18];

   function automatic logic [31:0] ins(input logic [5:0] op,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
      return {op, rs, rt, 16'h0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      inst = 32'h0; rex = 0; wex = 0; mrex = 0;
      rmem = 0; wmem = 0; rwb = 0; wwb = 0; br = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clr();
      #1;
      chk("rst_pc_en", pc_en, 0);
      chk("rst_if_id_en", if_id_en, 0);
      chk("rst_flush", if_id_flush, 1);
      chk("rst_bubble", id_ex_bubble, 1);
      chk("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_st = 0;
      exp_fl = 0;
   endtask

   task automatic chk_ctrl(input string nm, input logic p, input logic e,
                           input logic f, input logic b);
      chk({nm, "_pc_en"}, pc_en, p);
      chk({nm, "_if_id_en"}, if_id_en, e);
      chk({nm, "_flush"}, if_id_flush, f);
      chk({nm, "_bubble"}, id_ex_bubble, b);
   endtask

   initial begin
      reset = 1'b1;
      clr();
      //       inst              rex w m  rmem w  rwb w  br nf fw fa fb
      v[0]  = '{ins(6'h00,1,2),  1, 1,0, 0, 0,  0, 0,  0, 1,0, 0,0};
      v[1]  = '{ins(6'h00,1,2),  2, 1,1, 0, 0,  0, 0,  0, 1,1, 0,0};
      v[2]  = '{ins(6'h00,0,0),  0, 1,1, 0, 1,  0, 1,  0, 0,0, 0,0};
      v[3]  = '{ins(6'h0A,5,6),  5, 0,1, 0, 0,  0, 0,  0, 0,0, 0,0};
      v[4]  = '{ins(6'h01,4,5),  0, 0,0, 5, 1,  0, 0,  0, 0,0, 0,0};
      v[5]  = '{ins(6'h01,4,9),  0, 0,0, 4, 1,  0, 0,  0, 1,0, 1,0};
      v[6]  = '{ins(6'h01,5,4),  0, 0,0, 5, 1,  5, 1,  0, 1,0, 1,0};
      v[7]  = '{ins(6'h0D,6,7),  0, 0,0, 0, 0,  7, 1,  0, 1,0, 0,2};
      v[8]  = '{ins(6'h0F,8,9),  0, 0,0, 8, 1,  9, 1,  0, 1,0, 1,2};
      v[9]  = '{ins(6'h0E,0,10), 10,1,1, 0, 0,  0, 0,  0, 0,0, 0,0};
      v[10] = '{ins(6'h10,11,0), 11,1,1, 0, 0,  0, 0,  0, 1,1, 0,0};
      v[11] = '{ins(6'h3F,13,13),13,1,1, 13,1,  13,1,  0, 0,0, 0,0};
      v[12] = '{ins(6'h0C,14,3), 0, 0,0, 3, 1,  14,1,  0, 1,0, 2,0};
      v[13] = '{ins(6'h02,3,15), 0, 0,0, 15,0,  15,1,  0, 1,0, 0,2};
      v[14] = '{ins(6'h11,1,1),  1, 1,1, 0, 0,  0, 0,  1, 0,0, 0,0};
      v[15] = '{ins(6'h00,1,2),  1, 1,1, 2, 1,  0, 0,  1, 0,0, 0,1};
      v[16] = '{ins(6'h06,20,21),0, 0,0, 20,1,  21,1,  0, 1,0, 1,2};
      v[17] = '{ins(6'h08,7,7),  0, 0,0, 7, 1,  7, 1,  0, 1,0, 1,1};

      // Reset, then first cycle out of reset with a NOP in ID.
      do_reset();
      #1;
      chk_ctrl("post_rst", 1, 1, 0, 0);
      chk("post_rst_stall_cnt", stall_cnt, 0);
      chk("post_rst_flush_cnt", flush_cnt, 0);
      chk("post_rst_halted", halted, 0);

      // Vector table, all in RUN.
      foreach (v[i]) begin
         logic st;
         @(negedge clk);
         inst = v[i].inst; rex = v[i].rex; wex = v[i].wex;
         mrex = v[i].mrex; rmem = v[i].rmem; wmem = v[i].wmem;
         rwb = v[i].rwb; wwb = v[i].wwb; br = v[i].br;
         st = FWD ? v[i].st_fw : v[i].st_nf;
         #1;
         if (v[i].br)  chk_ctrl($sformatf("v%0d", i), 1, 1, 1, 1);
         else if (st)  chk_ctrl($sformatf("v%0d", i), 0, 0, 0, 1);
         else          chk_ctrl($sformatf("v%0d", i), 1, 1, 0, 0);
         chk($sformatf("v%0d_fa", i), fwd_a_sel, FWD ? v[i].fa : 2'd0);
         chk($sformatf("v%0d_fb", i), fwd_b_sel, FWD ? v[i].fb : 2'd0);
         if (v[i].br) exp_fl = (exp_fl < 15) ? exp_fl + 1 : 15;
         else if (st) exp_st = (exp_st < 15) ? exp_st + 1 : 15;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_stall_cnt", i), stall_cnt, exp_st);
         chk($sformatf("v%0d_flush_cnt", i), flush_cnt, exp_fl);
      end

      // Load result r3 walks EX -> MEM -> WB while ADD r4,r3,r2 waits.
      do_reset();
      inst = ins(6'h00, 3, 2);
      rex = 3; wex = 1; mrex = 1;
      #1 chk("raw_ex_pc_en", pc_en, 0);
      chk("raw_ex_bubble", id_ex_bubble, 1);
      @(negedge clk);
      rex = 0; wex = 0; mrex = 0; rmem = 3; wmem = 1;
      #1 chk("raw_mem_pc_en", pc_en, FWD);
      chk("raw_mem_fa", fwd_a_sel, FWD ? 2'd1 : 2'd0);
      @(negedge clk);
      rmem = 0; wmem = 0; rwb = 3; wwb = 1;
      #1 chk("raw_wb_pc_en", pc_en, FWD);
      @(negedge clk);
      rwb = 0; wwb = 0;
      #1 chk("raw_done_pc_en", pc_en, 1);
      @(posedge clk);
      #1 chk("raw_stall_cnt", stall_cnt, FWD ? 1 : 3);

      // Taken branch beats a HALT in ID.
      do_reset();
      inst = ins(6'h11, 1, 1);
      rex = 1; wex = 1; mrex = 1; br = 1;
      #1 chk_ctrl("br_halt", 1, 1, 1, 1);
      @(posedge clk);
      #1 chk("br_flush_cnt", flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 0);
      @(negedge clk);
      clr();
      #1 chk_ctrl("br_after", 1, 1, 0, 0);

      // HALT drain: 3 DRAIN cycles, halted on the 4th.
      @(negedge clk);
      inst = ins(6'h11, 0, 0);
      #1 chk_ctrl("halt_id", 0, 0, 0, 1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1 chk($sformatf("drain%0d_halted", k), halted, 0);
         chk_ctrl($sformatf("drain%0d", k), 0, 0, 0, 1);
      end
      @(posedge clk);
      #1 chk("halted_set", halted, 1);
      inst = 32'h0;
      repeat (2) begin
         @(posedge clk);
         #1 chk_ctrl("halted_hold", 0, 0, 0, 1);
         chk("halted_hold_h", halted, 1);
      end
      do_reset();
      #1 chk("unhalt_pc_en", pc_en, 1);
      chk("unhalt_halted", halted, 0);

      // Reset in the middle of DRAIN.
      @(negedge clk);
      inst = ins(6'h11, 0, 0);
      @(posedge clk);
      @(posedge clk);
      do_reset();
      #1 chk("middrain_pc_en", pc_en, 1);
      repeat (4) @(posedge clk);
      #1 chk("middrain_halted", halted, 0);
      chk("middrain_run", pc_en, 1);

      // Counter saturation: 2^CNT_W+2 stall cycles.
      do_reset();
      inst = ins(6'h00, 1, 2);
      rex = 1; wex = 1; mrex = 1;
      repeat (18) @(posedge clk);
      #1 chk("sat_stall_cnt", stall_cnt, 15);
      chk("sat_pc_en", pc_en, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
